// File: rtl/dsm_rate_pkg.sv
// Shared types and constants for the DSM rate scheduler (dsm_rate_ctrl).
// The optional underflow frame counter is enabled by DSM_RATE_UFLOW_CNT_EN.
package dsm_rate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Programmed zeros are promoted to these minimum effective values.
    localparam int DIV_MIN = 1;
    localparam int OSR_MIN = 1;

    localparam int UFLOW_W = 16;

endpackage

// File: rtl/dsm_rate_tick_gen.sv
// Programmable terminal-count divider: emits mod_ce once every div_eff cycles
// while running and toggles clk_out on each mod_ce.
module dsm_tick_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             restart,
    input  logic [CNT_W-1:0] div_eff,
    output logic             mod_ce,
    output logic             clk_out
);

    logic [CNT_W-1:0] tick_cnt;

    assign mod_ce = run && (tick_cnt == div_eff - CNT_W'(1));

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            clk_out  <= 1'b0;
        end else if (clear) begin
            tick_cnt <= '0;
            clk_out  <= 1'b0;
        end else begin
            if (mod_ce) begin
                clk_out <= ~clk_out;
            end
            if (restart || mod_ce) begin
                tick_cnt <= '0;
            end else if (run) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dsm_rate_ctrl.sv
// Rate scheduler for the DSM DAC: modulator clock-enable, sample frames and
// upstream handshake. Define DSM_RATE_UFLOW_CNT_EN to add the uflow_cnt output.
module dsm_rate_ctrl
    import dsm_rate_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int OSR_W   = 8,
    parameter int DIV_RST = 2,
    parameter int OSR_RST = 64
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [OSR_W-1:0]   cfg_osr,
    input  logic               cfg_load,
    output logic               cfg_ack,
    input  logic               smp_valid,
    output logic               smp_ready,
    output logic               smp_load,
    output logic               mod_ce,
    output logic               clk_out,
    output logic               underflow,
`ifdef DSM_RATE_UFLOW_CNT_EN
    output logic [UFLOW_W-1:0] uflow_cnt,
`endif
    output logic               busy
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [OSR_W-1:0] osr;
    } rate_cfg_t;

    state_t           state;
    state_t           state_nxt;
    rate_cfg_t        act;
    rate_cfg_t        shadow;
    logic             pend;
    logic [CNT_W-1:0] div_eff;
    logic [OSR_W-1:0] osr_eff;
    logic [OSR_W-1:0] frame_cnt;
    logic             rdy_q;
    logic             acc_q;
    logic             load_q;
    logic             ack_q;
    logic             xfer;
    logic             fb;
    logic             idle_path;
    logic             uflow_evt;

    assign div_eff = (act.div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : act.div;
    assign osr_eff = (act.osr < OSR_W'(OSR_MIN)) ? OSR_W'(OSR_MIN) : act.osr;

    assign xfer      = smp_valid && smp_ready;
    assign fb        = mod_ce && (frame_cnt == osr_eff - OSR_W'(1));
    // Disable wins over everything else and behaves exactly like sitting in IDLE.
    assign idle_path = !en || (state == IDLE);
    assign uflow_evt = !idle_path && (state == RUN) && fb && !(acc_q || xfer);

    dsm_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .clear   (idle_path),
        .run     (state == RUN),
        .restart (((state == PRIME) && xfer) || fb),
        .div_eff (div_eff),
        .mod_ce  (mod_ce),
        .clk_out (clk_out)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: each always_comb assigns its outputs a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = PRIME;
            PRIME:   if (!en) state_nxt = IDLE;
                     else if (xfer) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        smp_ready = 1'b0;
        unique case (state)
            PRIME:   smp_ready = 1'b1;
            RUN:     smp_ready = rdy_q;
            default: smp_ready = 1'b0;
        endcase
        busy = (state != IDLE);
    end

    // Shadow/active configuration: immediate when idle, otherwise at frame boundaries.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            act    <= '{div: CNT_W'(DIV_RST), osr: OSR_W'(OSR_RST)};
            shadow <= '0;
            pend   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (idle_path) begin
                pend <= 1'b0;
                if (cfg_load) begin
                    act   <= '{div: cfg_div, osr: cfg_osr};
                    ack_q <= 1'b1;
                end else if (pend) begin
                    act   <= shadow;
                    ack_q <= 1'b1;
                end
            end else begin
                if (fb && pend) begin
                    act   <= shadow;
                    ack_q <= 1'b1;
                    pend  <= cfg_load;
                end else if (cfg_load) begin
                    pend <= 1'b1;
                end
                if (cfg_load) begin
                    shadow <= '{div: cfg_div, osr: cfg_osr};
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            rdy_q     <= 1'b0;
            acc_q     <= 1'b0;
            load_q    <= 1'b0;
            underflow <= 1'b0;
        end else if (idle_path) begin
            frame_cnt <= '0;
            rdy_q     <= 1'b0;
            acc_q     <= 1'b0;
            load_q    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (state == PRIME) begin
                frame_cnt <= '0;
                rdy_q     <= 1'b0;
                acc_q     <= 1'b0;
                load_q    <= xfer;
            end else if (state == RUN) begin
                if (xfer) begin
                    rdy_q <= 1'b0;
                end else if (load_q) begin
                    rdy_q <= 1'b1;
                end
                if (fb) begin
                    frame_cnt <= '0;
                    acc_q     <= 1'b0;
                    load_q    <= acc_q || xfer;
                    if (uflow_evt) begin
                        underflow <= 1'b1;
                    end
                end else begin
                    if (mod_ce) begin
                        frame_cnt <= frame_cnt + OSR_W'(1);
                    end
                    if (xfer) begin
                        acc_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DSM_RATE_UFLOW_CNT_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            uflow_cnt <= '0;
        end else if (idle_path) begin
            uflow_cnt <= '0;
        end else if (uflow_evt && (uflow_cnt != '1)) begin
            uflow_cnt <= uflow_cnt + UFLOW_W'(1);
        end
    end
`endif

    assign smp_load = load_q;
    assign cfg_ack  = ack_q;

endmodule

// File: tb/tb_dsm_rate_ctrl.sv
// Self-checking bench for dsm_rate_ctrl against a frame-position reference model.
// Honours DSM_RATE_UFLOW_CNT_EN when the design is built with it.
module tb_dsm_rate_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_osr;
    logic        cfg_load;
    logic        cfg_ack;
    logic        smp_valid;
    logic        smp_ready;
    logic        smp_load;
    logic        mod_ce;
    logic        clk_out;
    logic        underflow;
    logic        busy;
`ifdef DSM_RATE_UFLOW_CNT_EN
    logic [15:0] uflow_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: mode 0/1/2 = idle/prime/run; pos = clk_in cycle within the frame.
    int m_mode, m_div, m_osr, m_sh_div, m_sh_osr, m_pos, m_ucnt;
    bit m_pend, m_clk, m_rdy, m_acc, m_uf, m_load, m_ack;

    dsm_rate_ctrl u_dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_osr   (cfg_osr),
        .cfg_load  (cfg_load),
        .cfg_ack   (cfg_ack),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_load  (smp_load),
        .mod_ce    (mod_ce),
        .clk_out   (clk_out),
        .underflow (underflow),
`ifdef DSM_RATE_UFLOW_CNT_EN
        .uflow_cnt (uflow_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_div = 2; m_osr = 64; m_sh_div = 0; m_sh_osr = 0;
        m_pos = 0; m_ucnt = 0; m_pend = 0; m_clk = 0; m_rdy = 0;
        m_acc = 0; m_uf = 0; m_load = 0; m_ack = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mod_ce"}, mod_ce, 0);
        chk({tag, ".clk_out"}, clk_out, 0);
        chk({tag, ".smp_ready"}, smp_ready, 0);
        chk({tag, ".smp_load"}, smp_load, 0);
        chk({tag, ".cfg_ack"}, cfg_ack, 0);
        chk({tag, ".underflow"}, underflow, 0);
        chk({tag, ".busy"}, busy, 0);
`ifdef DSM_RATE_UFLOW_CNT_EN
        chk({tag, ".uflow_cnt"}, uflow_cnt, 0);
`endif
    endtask

    // One clk_in cycle: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        int d, o;
        bit e_ce, e_fb, e_rdy, xfer, was_load;
        @(negedge clk_in);
        d     = (m_div < 1) ? 1 : m_div;
        o     = (m_osr < 1) ? 1 : m_osr;
        e_ce  = (m_mode == 2) && ((m_pos % d) == d - 1);
        e_fb  = e_ce && (m_pos == d * o - 1);
        e_rdy = (m_mode == 1) || ((m_mode == 2) && m_rdy);
        chk("mod_ce", mod_ce, e_ce);
        chk("smp_ready", smp_ready, e_rdy);
        chk("smp_load", smp_load, m_load);
        chk("cfg_ack", cfg_ack, m_ack);
        chk("clk_out", clk_out, m_clk);
        chk("underflow", underflow, m_uf);
        chk("busy", busy, m_mode != 0);
`ifdef DSM_RATE_UFLOW_CNT_EN
        chk("uflow_cnt", uflow_cnt, m_ucnt);
`endif
        xfer     = smp_valid && e_rdy;
        was_load = m_load;
        if (!en || m_mode == 0) begin
            if (cfg_load) begin
                m_div = cfg_div; m_osr = cfg_osr; m_ack = 1;
            end else if (m_pend) begin
                m_div = m_sh_div; m_osr = m_sh_osr; m_ack = 1;
            end else begin
                m_ack = 0;
            end
            m_pend = 0;
            m_mode = (m_mode == 0 && en) ? 1 : 0;
            m_pos = 0; m_clk = 0; m_rdy = 0; m_acc = 0; m_load = 0; m_uf = 0; m_ucnt = 0;
        end else if (m_mode == 1) begin
            m_ack = 0;
            if (cfg_load) begin
                m_sh_div = cfg_div; m_sh_osr = cfg_osr; m_pend = 1;
            end
            m_load = xfer;
            if (xfer) begin
                m_mode = 2; m_pos = 0;
            end
        end else begin
            m_ack = 0; m_load = 0;
            if (e_ce) m_clk = !m_clk;
            if (e_fb) begin
                if (m_acc || xfer) begin
                    m_load = 1;
                end else begin
                    m_uf = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
                if (m_pend) begin
                    m_div = m_sh_div; m_osr = m_sh_osr; m_ack = 1; m_pend = 0;
                end
                m_pos = 0; m_acc = 0;
            end else begin
                m_pos++;
                if (xfer) m_acc = 1;
            end
            if (cfg_load) begin
                m_sh_div = cfg_div; m_sh_osr = cfg_osr; m_pend = 1;
            end
            if (xfer) m_rdy = 0;
            else if (was_load) m_rdy = 1;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input int vpct);
        for (int i = 0; i < n; i++) begin
            smp_valid = ($urandom_range(99) < vpct);
            step();
        end
    endtask

    task automatic load_cfg(input int div, input int osr);
        cfg_div  = 16'(div);
        cfg_osr  = 8'(osr);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_div = '0; cfg_osr = '0;
        cfg_load = 1'b0; smp_valid = 1'b0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;

        // Defaults (div 2, osr 64) with a source that is always ready.
        en = 1'b1;
        run(300, 100);

        // Mid-frame reconfiguration to div 5, osr 4.
        load_cfg(5, 4);
        run(120, 100);

        // Zero divisor/OSR loaded while idle: both behave as 1.
        en = 1'b0;
        run(2, 100);
        load_cfg(0, 0);
        en = 1'b1;
        run(30, 100);

        // Underflow: one full frame without samples at div 3, osr 8.
        en = 1'b0;
        run(1, 0);
        load_cfg(3, 8);
        en = 1'b1;
        run(2, 100);
        run(24, 100);
        run(24, 0);
        run(48, 100);
        chk("underflow_sticky", underflow, 1);

        // Two loads inside one frame: only the later one takes effect.
        run(3, 100);
        load_cfg(4, 8);
        run(2, 100);
        load_cfg(7, 8);
        run(80, 100);

        // Drop enable mid-frame.
        run(5, 100);
        en = 1'b0;
        run(1, 100);
        chk("en_drop.busy", busy, 0);
        chk("en_drop.mod_ce", mod_ce, 0);
        chk("en_drop.clk_out", clk_out, 0);
        run(2, 100);

        // Randomised configuration, sample availability and enable.
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            smp_valid = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 2) begin
                cfg_div  = 16'($urandom_range(6));
                cfg_osr  = 8'($urandom_range(9));
                cfg_load = 1'b1;
            end
            en = ($urandom_range(199) != 0);
            step();
            cfg_load = 1'b0;
        end

        // Asynchronous reset in the middle of a frame.
        en = 1'b1;
        run(40, 100);
        async_reset("mid_reset");
        run(60, 90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
